// File: rtl/sort_run_controller.sv
// -----------------------------------------------------------------------------
// sort_run_controller
//
// Sequences one selection-sort run on the RISC_V_Processor core:
//    1. IDLE  : waits for a start pulse.
//    2. LOAD  : owns the data-memory write port and streams N_ELEM elements
//               into the array region (element i at BASE_ADDR + 8*i).
//    3. BOOT  : hands memory back to the core and holds it in reset for one
//               more cycle so it starts cleanly at PC 0.
//    4. RUN   : releases the core, counts cycles, and watches the PC for the
//               terminating jump-to-self at HALT_PC.
//    5. DONE  : freezes the core; results are valid in memory.
//
// Optional feature macro: SORT_WDOG_EN
//    Defined   -> a RUN that reaches WDOG_LIMIT cycles without halting ends in
//                 DONE with timeout=1.
//    Undefined -> no watchdog; timeout is tied to 0.
//
// Ports
//    clk          in   1       clock, all state on rising edge
//    reset        in   1       synchronous, active-high
//    start        in   1       single-cycle run request (honoured in IDLE/DONE)
//    load_valid   in   1       element available on load_data
//    load_data    in   DATA_W  element value
//    load_ready   out  1       controller accepts an element this cycle
//    core_reset   out  1       holds the processor in reset
//    core_pc      in   64      processor program counter
//    dmem_sel     out  1       1 = controller drives data memory, 0 = core
//    dmem_we      out  1       data-memory write enable (controller side)
//    dmem_addr    out  ADDR_W  data-memory byte address
//    dmem_wdata   out  DATA_W  data-memory write data
//    busy         out  1       run in progress (LOAD/BOOT/RUN)
//    done         out  1       run finished
//    cycle_count  out  CNT_W   cycles spent in RUN (saturating)
//    timeout      out  1       run ended by the watchdog
// -----------------------------------------------------------------------------
module sort_run_controller #(
   parameter int                N_ELEM     = 8,
   parameter int                DATA_W     = 64,
   parameter int                ADDR_W     = 10,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = 'h100,
   parameter logic [63:0]       HALT_PC    = 64'h0C8,
   parameter int                CNT_W      = 64,
   parameter int                WDOG_LIMIT = 4096
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_ready,
   output logic              core_reset,
   input  logic [63:0]       core_pc,
   output logic              dmem_sel,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  cycle_count,
   output logic              timeout
);

   localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_BOOT,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state, state_d;
   logic [IDX_W-1:0] idx;
   logic             halt_seen;
   logic             accept;
   logic             at_halt_pc;
   logic             halt;
   logic             wdog_hit;
   logic             restart;

   assign accept     = (state == S_LOAD) && load_valid;
   assign at_halt_pc = (core_pc == HALT_PC);
   // The halt instruction is a jump-to-self, so the PC sits at HALT_PC on two
   // consecutive cycles; a single visit is just passing through.
   assign halt       = (state == S_RUN) && halt_seen && at_halt_pc;
   assign restart    = (state == S_DONE) && start;
   assign dmem_addr  = BASE_ADDR + ADDR_W'({idx, 3'b000});

`ifdef SORT_WDOG_EN
   localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_LIMIT - 1);
   logic timeout_q;

   // Halt on the limit cycle wins: the run completed, it did not time out.
   assign wdog_hit = (state == S_RUN) && (cycle_count == WDOG_LAST) && !halt;
   assign timeout  = timeout_q;
`else
   assign wdog_hit = 1'b0;
   assign timeout  = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         idx         <= '0;
         halt_seen   <= 1'b0;
         cycle_count <= '0;
      end else begin
         state     <= state_d;
         halt_seen <= (state == S_RUN) && at_halt_pc;

         if (restart) begin
            idx         <= '0;
            cycle_count <= '0;
         end else begin
            if (accept) begin
               idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
            if ((state == S_RUN) && !(&cycle_count)) begin
               cycle_count <= cycle_count + 1'b1;
            end
         end
      end
   end

`ifdef SORT_WDOG_EN
   always_ff @(posedge clk) begin
      if (reset || restart) begin
         timeout_q <= 1'b0;
      end else if (wdog_hit) begin
         timeout_q <= 1'b1;
      end
   end
`endif

   // NOTE: every output of this block gets a default first, so no path through
   // the case statement can leave a signal unassigned and infer a latch.
   always_comb begin
      state_d    = state;
      load_ready = 1'b0;
      core_reset = 1'b1;
      dmem_sel   = 1'b1;
      dmem_we    = 1'b0;
      dmem_wdata = '0;
      busy       = 1'b0;
      done       = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) state_d = S_LOAD;
         end
         S_LOAD: begin
            load_ready = 1'b1;
            busy       = 1'b1;
            dmem_we    = accept;
            dmem_wdata = load_data;
            if (accept && (idx == LAST_IDX)) state_d = S_BOOT;
         end
         S_BOOT: begin
            dmem_sel = 1'b0;
            busy     = 1'b1;
            state_d  = S_RUN;
         end
         S_RUN: begin
            core_reset = 1'b0;
            dmem_sel   = 1'b0;
            busy       = 1'b1;
            if (halt || wdog_hit) state_d = S_DONE;
         end
         S_DONE: begin
            done = 1'b1;
            if (start) state_d = S_LOAD;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_sort_run_controller.sv
// -----------------------------------------------------------------------------
// tb_sort_run_controller
//
// Directed bench for sort_run_controller. Inputs change right after a falling
// edge; outputs are sampled 1 time unit later, well away from the rising edge.
// With SORT_WDOG_EN the watchdog limit is set above the length of the halting
// run so that run still ends by halt.
// -----------------------------------------------------------------------------
module tb_sort_run_controller;

   localparam int          N_ELEM  = 8;
   localparam int          DATA_W  = 64;
   localparam int          ADDR_W  = 10;
   localparam int          CNT_W   = 64;
   localparam logic [63:0] HALT_PC = 64'h0C8;
`ifdef SORT_WDOG_EN
   localparam int          WDOG    = 40;
`else
   localparam int          WDOG    = 16;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              load_valid;
   logic [DATA_W-1:0] load_data;
   logic              load_ready;
   logic              core_reset;
   logic [63:0]       core_pc;
   logic              dmem_sel;
   logic              dmem_we;
   logic [ADDR_W-1:0] dmem_addr;
   logic [DATA_W-1:0] dmem_wdata;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  cycle_count;
   logic              timeout;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sort_run_controller #(
      .N_ELEM     (N_ELEM),
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .BASE_ADDR  (10'h100),
      .HALT_PC    (HALT_PC),
      .CNT_W      (CNT_W),
      .WDOG_LIMIT (WDOG)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_ready  (load_ready),
      .core_reset  (core_reset),
      .core_pc     (core_pc),
      .dmem_sel    (dmem_sel),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_wdata  (dmem_wdata),
      .busy        (busy),
      .done        (done),
      .cycle_count (cycle_count),
      .timeout     (timeout)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] pc_for(input int k);
      if (k == 10 || k >= 37) return HALT_PC;
      return 64'((k - 1) * 4);
   endfunction

   int pat [20] = '{1,0,0,1,1,0,1,0,0,1,1,1,0,1,1,0,1,1,1,1};
   int acc;

   initial begin
      reset = 1'b1; start = 1'b0; load_valid = 1'b0; load_data = '0; core_pc = '0;

      // Two reset cycles -> idle values.
      repeat (2) @(negedge clk);
      #1;
      chk("rst_core_reset", core_reset, 1);
      chk("rst_dmem_sel",   dmem_sel, 1);
      chk("rst_load_ready", load_ready, 0);
      chk("rst_dmem_we",    dmem_we, 0);
      chk("rst_dmem_addr",  dmem_addr, 'h100);
      chk("rst_dmem_wdata", dmem_wdata, 0);
      chk("rst_busy",       busy, 0);
      chk("rst_done",       done, 0);
      chk("rst_cycle_cnt",  cycle_count, 0);
      chk("rst_timeout",    timeout, 0);

      // Start, then stream 8..1 with valid held high; start pulse at i=3 ignored.
      reset = 1'b0; start = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         start = (i == 3); load_valid = 1'b1; load_data = 64'(8 - i);
         #1;
         chk("load_ready", load_ready, 1);
         chk("load_we",    dmem_we, 1);
         chk("load_addr",  dmem_addr, 64'('h100 + 8 * i));
         chk("load_wdata", dmem_wdata, 64'(8 - i));
         chk("load_core_reset", core_reset, 1);
         @(negedge clk);
      end

      // BOOT cycle.
      start = 1'b0; load_valid = 1'b0;
      #1;
      chk("boot_load_ready", load_ready, 0);
      chk("boot_dmem_sel",   dmem_sel, 0);
      chk("boot_core_reset", core_reset, 1);
      chk("boot_busy",       busy, 1);
      chk("boot_we",         dmem_we, 0);
      @(negedge clk);

      // RUN: single HALT_PC visit at k=10, real halt on k=37/38; start at k=5 ignored.
      for (int k = 1; k <= 38; k++) begin
         core_pc = pc_for(k); start = (k == 5);
         #1;
         if (k == 1) begin
            chk("run_core_reset", core_reset, 0);
            chk("run_dmem_sel",   dmem_sel, 0);
            chk("run_busy",       busy, 1);
            chk("run_cnt_start",  cycle_count, 0);
         end
         if (k == 12) begin
            chk("one_visit_busy", busy, 1);
            chk("one_visit_done", done, 0);
         end
         if (k == 38) chk("run_cnt_pre_halt", cycle_count, 37);
         @(negedge clk);
      end

      start = 1'b0;
      #1;
      chk("halt_done",       done, 1);
      chk("halt_busy",       busy, 0);
      chk("halt_cycle_cnt",  cycle_count, 38);
      chk("halt_core_reset", core_reset, 1);
      chk("halt_dmem_sel",   dmem_sel, 1);
      chk("halt_timeout",    timeout, 0);
      @(negedge clk);
      #1;
      chk("done_cnt_frozen", cycle_count, 38);

      // Start from DONE -> fresh LOAD with bubbly valid pattern.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; core_pc = '0;
      #1;
      chk("rerun_done",      done, 0);
      chk("rerun_cycle_cnt", cycle_count, 0);
      chk("rerun_busy",      busy, 1);
      chk("rerun_ready",     load_ready, 1);

      acc = 0;
      for (int i = 0; i < 20 && acc < 8; i++) begin
         load_valid = pat[i][0]; load_data = 64'('hA0 + acc);
         #1;
         chk("bubble_we",   dmem_we, pat[i][0]);
         chk("bubble_addr", dmem_addr, 64'('h100 + 8 * acc));
         if (pat[i] != 0) acc++;
         @(negedge clk);
      end
      chk("bubble_accepts", acc, 8);

      load_valid = 1'b0;
      #1;
      chk("bubble_boot_ready", load_ready, 0);
      @(negedge clk);

      // Non-halting run.
      core_pc = 64'h10;
`ifdef SORT_WDOG_EN
      repeat (WDOG) @(negedge clk);
      #1;
      chk("wdog_done",      done, 1);
      chk("wdog_timeout",   timeout, 1);
      chk("wdog_cycle_cnt", cycle_count, WDOG);
      chk("wdog_busy",      busy, 0);
`else
      repeat (100) @(negedge clk);
      #1;
      chk("nowdog_busy",       busy, 1);
      chk("nowdog_done",       done, 0);
      chk("nowdog_timeout",    timeout, 0);
      chk("nowdog_cycle_cnt",  cycle_count, 100);
      chk("nowdog_core_reset", core_reset, 0);
`endif

      // Reset in the middle of a load -> back to IDLE with idx=0.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         load_valid = 1'b1; load_data = 64'(i + 1);
         @(negedge clk);
      end
      reset = 1'b1; load_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midrst_busy",       busy, 0);
      chk("midrst_ready",      load_ready, 0);
      chk("midrst_addr",       dmem_addr, 'h100);
      chk("midrst_core_reset", core_reset, 1);
      chk("midrst_dmem_sel",   dmem_sel, 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; load_valid = 1'b1; load_data = 64'h55;
      #1;
      chk("midrst_restart_we",   dmem_we, 1);
      chk("midrst_restart_addr", dmem_addr, 'h100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
